// File: rtl/pipe_pkg.sv
// Shared types and constants for the ID/EX pipeline stage.
// Holds the EX occupancy FSM encoding, ALUOp width and the ID/EX register layout.
package pipe_pkg;
   localparam int ALUOP_W        = 4;
   localparam int CNT_W          = 4;
   localparam int MULDIV_LAT_DEF = 4;

   typedef enum logic {
      RUN     = 1'b0,
      MD_BUSY = 1'b1
   } ex_state_e;

   typedef struct packed {
      logic               valid;
      logic [4:0]         rs;
      logic [4:0]         rt;
      logic [4:0]         wr;
      logic [31:0]        rs_data;
      logic [31:0]        rt_data;
      logic [31:0]        imm;
      logic [31:0]        pc;
      logic               reg_write;
      logic               mem_read;
      logic               mem_write;
      logic               mem_to_reg;
      logic               alu_src;
      logic               is_muldiv;
      logic [ALUOP_W-1:0] alu_op;
   } id_ex_t;
endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use detector: a load sitting in EX whose destination
// is read by the instruction currently in ID.
module hazard_detect (
   input  logic       ex_valid,
   input  logic       ex_mem_read,
   input  logic [4:0] ex_wr,
   input  logic       id_valid,
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic       id_uses_rt,
   output logic       load_use
);
   logic rs_match;
   logic rt_match;

   // $0 is never a real dependency, so a load targeting it never stalls.
   assign rs_match = (ex_wr == id_rs);
   assign rt_match = id_uses_rt & (ex_wr == id_rt);
   assign load_use = ex_valid & ex_mem_read & (ex_wr != 5'd0) & id_valid
                   & (rs_match | rt_match);
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and a multi-cycle
// mul/div occupancy FSM that holds the stage while EX is busy.
module id_ex_stage
   import pipe_pkg::*;
#(
   parameter int MULDIV_LAT = MULDIV_LAT_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               IF_ID_valid,
   input  logic [4:0]         IF_ID_rs,
   input  logic [4:0]         IF_ID_rt,
   input  logic [4:0]         IF_ID_rd,
   input  logic               IF_ID_uses_rt,
   input  logic [31:0]        rs_data,
   input  logic [31:0]        rt_data,
   input  logic [31:0]        imm,
   input  logic [31:0]        IF_ID_pc,
   input  logic               RegWrite,
   input  logic               MemRead,
   input  logic               MemWrite,
   input  logic               MemtoReg,
   input  logic               ALUSrc,
   input  logic               RegDst,
   input  logic               is_muldiv,
   input  logic [ALUOP_W-1:0] ALUOp,
   input  logic               flush,
   output logic               ID_EX_valid,
   output logic [4:0]         ID_EX_rs,
   output logic [4:0]         ID_EX_rt,
   output logic [4:0]         ID_EX_wr,
   output logic [31:0]        ID_EX_rs_data,
   output logic [31:0]        ID_EX_rt_data,
   output logic [31:0]        ID_EX_imm,
   output logic [31:0]        ID_EX_pc,
   output logic               ID_EX_RegWrite,
   output logic               ID_EX_MemRead,
   output logic               ID_EX_MemWrite,
   output logic               ID_EX_MemtoReg,
   output logic               ID_EX_ALUSrc,
   output logic               ID_EX_is_muldiv,
   output logic [ALUOP_W-1:0] ID_EX_ALUOp,
   output logic               stall,
   output logic               ex_busy
);
   localparam logic [CNT_W-1:0] MD_LOAD = CNT_W'(MULDIV_LAT - 1);

   ex_state_e        state, nxt_state;
   logic [CNT_W-1:0] cnt, nxt_cnt;
   id_ex_t           q, nxt_q, in_q;
   logic             load_use;

   hazard_detect u_hazard (
      .ex_valid    (q.valid),
      .ex_mem_read (q.mem_read),
      .ex_wr       (q.wr),
      .id_valid    (IF_ID_valid),
      .id_rs       (IF_ID_rs),
      .id_rt       (IF_ID_rt),
      .id_uses_rt  (IF_ID_uses_rt),
      .load_use    (load_use)
   );

   always_comb begin
      in_q            = '0;
      in_q.valid      = 1'b1;
      in_q.rs         = IF_ID_rs;
      in_q.rt         = IF_ID_rt;
      in_q.wr         = RegDst ? IF_ID_rd : IF_ID_rt;
      in_q.rs_data    = rs_data;
      in_q.rt_data    = rt_data;
      in_q.imm        = imm;
      in_q.pc         = IF_ID_pc;
      in_q.reg_write  = RegWrite;
      in_q.mem_read   = MemRead;
      in_q.mem_write  = MemWrite;
      in_q.mem_to_reg = MemtoReg;
      in_q.alu_src    = ALUSrc;
      in_q.is_muldiv  = is_muldiv;
      in_q.alu_op     = ALUOp;
   end

   // Priority: flush, then mul/div hold, then load-use bubble, then normal load.
   always_comb begin
      nxt_state = state;
      nxt_cnt   = cnt;
      nxt_q     = q;
      if (flush) begin
         nxt_q     = '0;
         nxt_state = RUN;
         nxt_cnt   = '0;
      end else if (state == MD_BUSY) begin
         nxt_cnt = cnt - CNT_W'(1);
         if (cnt <= CNT_W'(1)) begin
            nxt_state = RUN;
            nxt_cnt   = '0;
         end
      end else if (load_use || !IF_ID_valid) begin
         nxt_q = '0;
      end else begin
         nxt_q = in_q;
         if (is_muldiv) begin
            nxt_state = MD_BUSY;
            nxt_cnt   = MD_LOAD;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= RUN;
         cnt   <= '0;
         q     <= '0;
      end else begin
         state <= nxt_state;
         cnt   <= nxt_cnt;
         q     <= nxt_q;
      end
   end

   assign ex_busy = (state == MD_BUSY);
   assign stall   = (load_use | ex_busy) & ~flush;

   assign ID_EX_valid     = q.valid;
   assign ID_EX_rs        = q.rs;
   assign ID_EX_rt        = q.rt;
   assign ID_EX_wr        = q.wr;
   assign ID_EX_rs_data   = q.rs_data;
   assign ID_EX_rt_data   = q.rt_data;
   assign ID_EX_imm       = q.imm;
   assign ID_EX_pc        = q.pc;
   assign ID_EX_RegWrite  = q.reg_write;
   assign ID_EX_MemRead   = q.mem_read;
   assign ID_EX_MemWrite  = q.mem_write;
   assign ID_EX_MemtoReg  = q.mem_to_reg;
   assign ID_EX_ALUSrc    = q.alu_src;
   assign ID_EX_is_muldiv = q.is_muldiv;
   assign ID_EX_ALUOp     = q.alu_op;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed scenarios plus randomized traffic for id_ex_stage, checked against
// a record-level model of what EX should hold and how many busy cycles remain.
module tb_id_ex_stage;
   localparam int LAT = 4;

   logic        clk, rst;
   logic        IF_ID_valid, IF_ID_uses_rt;
   logic [4:0]  IF_ID_rs, IF_ID_rt, IF_ID_rd;
   logic [31:0] rs_data, rt_data, imm, IF_ID_pc;
   logic        RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, RegDst, is_muldiv;
   logic [3:0]  ALUOp;
   logic        flush;
   logic        ID_EX_valid;
   logic [4:0]  ID_EX_rs, ID_EX_rt, ID_EX_wr;
   logic [31:0] ID_EX_rs_data, ID_EX_rt_data, ID_EX_imm, ID_EX_pc;
   logic        ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemtoReg;
   logic        ID_EX_ALUSrc, ID_EX_is_muldiv;
   logic [3:0]  ID_EX_ALUOp;
   logic        stall, ex_busy;

   id_ex_stage #(.MULDIV_LAT(LAT)) dut (
      .clk(clk), .rst(rst),
      .IF_ID_valid(IF_ID_valid), .IF_ID_rs(IF_ID_rs), .IF_ID_rt(IF_ID_rt),
      .IF_ID_rd(IF_ID_rd), .IF_ID_uses_rt(IF_ID_uses_rt),
      .rs_data(rs_data), .rt_data(rt_data), .imm(imm), .IF_ID_pc(IF_ID_pc),
      .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
      .MemtoReg(MemtoReg), .ALUSrc(ALUSrc), .RegDst(RegDst),
      .is_muldiv(is_muldiv), .ALUOp(ALUOp), .flush(flush),
      .ID_EX_valid(ID_EX_valid), .ID_EX_rs(ID_EX_rs), .ID_EX_rt(ID_EX_rt),
      .ID_EX_wr(ID_EX_wr), .ID_EX_rs_data(ID_EX_rs_data),
      .ID_EX_rt_data(ID_EX_rt_data), .ID_EX_imm(ID_EX_imm), .ID_EX_pc(ID_EX_pc),
      .ID_EX_RegWrite(ID_EX_RegWrite), .ID_EX_MemRead(ID_EX_MemRead),
      .ID_EX_MemWrite(ID_EX_MemWrite), .ID_EX_MemtoReg(ID_EX_MemtoReg),
      .ID_EX_ALUSrc(ID_EX_ALUSrc), .ID_EX_is_muldiv(ID_EX_is_muldiv),
      .ID_EX_ALUOp(ID_EX_ALUOp), .stall(stall), .ex_busy(ex_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      bit        v;
      bit [4:0]  rs, rt, wr;
      bit [31:0] rsd, rtd, imm, pc;
      bit        rw, mr, mw, m2r, as, md;
      bit [3:0]  op;
   } rec_t;

   rec_t m;
   int   busy_left;
   int   n_vec = 0;
   int   n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit m_hazard();
      return m.v && m.mr && m.wr != 0 && IF_ID_valid &&
             (m.wr == IF_ID_rs || (IF_ID_uses_rt && m.wr == IF_ID_rt));
   endfunction

   task automatic model_edge();
      if (flush) begin
         m = '0;
         busy_left = 0;
      end else if (busy_left > 0) begin
         busy_left--;
      end else if (m_hazard() || !IF_ID_valid) begin
         m = '0;
      end else begin
         m = '{v:1'b1, rs:IF_ID_rs, rt:IF_ID_rt, wr:(RegDst ? IF_ID_rd : IF_ID_rt),
               rsd:rs_data, rtd:rt_data, imm:imm, pc:IF_ID_pc, rw:RegWrite, mr:MemRead,
               mw:MemWrite, m2r:MemtoReg, as:ALUSrc, md:is_muldiv, op:ALUOp};
         if (is_muldiv) busy_left = LAT - 1;
      end
   endtask

   task automatic check_regs();
      chk("valid", ID_EX_valid, m.v);
      chk("rs", ID_EX_rs, m.rs);
      chk("rt", ID_EX_rt, m.rt);
      chk("wr", ID_EX_wr, m.wr);
      chk("rs_data", ID_EX_rs_data, m.rsd);
      chk("rt_data", ID_EX_rt_data, m.rtd);
      chk("imm", ID_EX_imm, m.imm);
      chk("pc", ID_EX_pc, m.pc);
      chk("ctl", {ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemtoReg,
                  ID_EX_ALUSrc, ID_EX_is_muldiv, ID_EX_ALUOp},
                 {m.rw, m.mr, m.mw, m.m2r, m.as, m.md, m.op});
      chk("ex_busy", ex_busy, busy_left > 0);
   endtask

   // Combinational checks just after inputs settle, before the rising edge.
   task automatic settle();
      #1;
      chk("stall", stall, (m_hazard() || busy_left > 0) && !flush);
      chk("ex_busy_c", ex_busy, busy_left > 0);
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      check_regs();
      @(negedge clk);
   endtask

   task automatic async_reset();
      rst = 1'b1;
      #1;
      m = '0;
      busy_left = 0;
      check_regs();
      chk("rst_stall", stall, m_hazard() && !flush);
      rst = 1'b0;
   endtask

   task automatic rand_payload();
      rs_data  = $urandom;
      rt_data  = $urandom;
      imm      = $urandom;
      IF_ID_pc = $urandom;
      RegWrite = 1'($urandom);
      MemWrite = 1'($urandom);
      MemtoReg = 1'($urandom);
      ALUSrc   = 1'($urandom);
      ALUOp    = 4'($urandom);
   endtask

   task automatic set_instr(input bit v, input int rs_i, input int rt_i, input int rd_i,
                            input bit ut, input bit mr, input bit rd_sel, input bit md);
      rand_payload();
      IF_ID_valid   = v;
      IF_ID_rs      = 5'(rs_i);
      IF_ID_rt      = 5'(rt_i);
      IF_ID_rd      = 5'(rd_i);
      IF_ID_uses_rt = ut;
      MemRead       = mr;
      RegDst        = rd_sel;
      is_muldiv     = md;
      flush         = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      set_instr(0, 0, 0, 0, 0, 0, 0, 0);
      m = '0;
      busy_left = 0;
      @(negedge clk);
      check_regs();
      rst = 1'b0;

      // lw $t0 then add reading $t0: one stall, a bubble, then the add
      set_instr(1, 1, 8, 0, 0, 1, 0, 0); settle(); tick();
      set_instr(1, 8, 2, 3, 1, 0, 1, 0); settle();
      chk("lu_stall", stall, 1);
      tick();
      chk("lu_bubble", ID_EX_valid, 0);
      settle();
      chk("lu_release", stall, 0);
      tick();
      chk("lu_add_rs", ID_EX_rs, 8);
      chk("lu_add_wr", ID_EX_wr, 3);

      // load into $0 never stalls a reader of $0
      set_instr(1, 1, 0, 0, 0, 1, 0, 0); settle(); tick();
      set_instr(1, 0, 0, 4, 1, 0, 1, 0); settle();
      chk("zero_stall", stall, 0);
      tick();
      chk("zero_valid", ID_EX_valid, 1);

      // lw $9 then sw reading rt=9 stalls; same rt without uses_rt does not
      set_instr(1, 1, 9, 0, 0, 1, 0, 0); settle(); tick();
      set_instr(1, 1, 9, 0, 1, 0, 0, 0); settle();
      chk("rt_stall", stall, 1);
      IF_ID_uses_rt = 1'b0;
      settle();
      chk("rt_nostall", stall, 0);
      tick();

      // mult holds EX for LAT cycles, next instruction loads on 4th edge
      set_instr(1, 2, 3, 0, 1, 0, 0, 1); settle(); tick();
      set_instr(1, 5, 6, 7, 1, 0, 1, 0);
      for (int k = 0; k < LAT - 1; k++) begin
         settle();
         chk("md_stall", stall, 1);
         chk("md_busy", ex_busy, 1);
         tick();
         chk("md_hold", ID_EX_is_muldiv, 1);
      end
      settle();
      chk("md_done", stall, 0);
      tick();
      chk("md_next_rs", ID_EX_rs, 5);

      // flush in the 2nd busy cycle wins
      set_instr(1, 2, 3, 0, 1, 0, 0, 1); settle(); tick();
      set_instr(1, 5, 6, 7, 1, 0, 1, 0); settle(); tick();
      flush = 1'b1;
      settle();
      chk("fl_stall", stall, 0);
      tick();
      chk("fl_valid", ID_EX_valid, 0);
      chk("fl_busy", ex_busy, 0);
      flush = 1'b0;

      // async reset mid-busy, then behave as RUN
      set_instr(1, 2, 3, 0, 1, 0, 0, 1); settle(); tick();
      #2;
      async_reset();
      chk("rst_valid", ID_EX_valid, 0);
      set_instr(1, 11, 12, 13, 1, 0, 1, 0); settle(); tick();
      chk("rst_run_rs", ID_EX_rs, 11);

      // randomized traffic with narrow register range to provoke hazards
      for (int i = 0; i < 600; i++) begin
         set_instr($urandom_range(0, 9) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), 1'($urandom), $urandom_range(0, 1) == 0,
                   1'($urandom), $urandom_range(0, 7) == 0);
         flush = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 49) == 0) async_reset();
         settle();
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 The block SHALL have parameter MULDIV_LAT, default 4, meaning total EX-occupancy cycles of a multiply/divide instruction (legal range 2..15).
REQ-002 The block SHALL have port: clk  input  1  single clock for all state.
REQ-003 The block SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port: IF_ID_valid  input  1  decoded instruction present.
REQ-005 The block SHALL have ports: IF_ID_rs, IF_ID_rt, IF_ID_rd  input  5 each  decoded register specifiers.
REQ-006 The block SHALL have port: IF_ID_uses_rt  input  1  instruction reads rt as a source.
REQ-007 The block SHALL have ports: rs_data, rt_data, imm, IF_ID_pc  input  32 each  register-file reads, sign-extended immediate, PC+4.
REQ-008 The block SHALL have ports: RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, RegDst, is_muldiv  input  1 each  decoded control.
REQ-009 The block SHALL have port: ALUOp  input  4  ALU operation.
REQ-010 The block SHALL have port: flush  input  1  branch/jump redirect resolved in EX.
REQ-011 The block SHALL have outputs ID_EX_valid (1), ID_EX_rs, ID_EX_rt, ID_EX_wr (5 each), ID_EX_rs_data, ID_EX_rt_data, ID_EX_imm, ID_EX_pc (32 each), ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemtoReg, ID_EX_ALUSrc, ID_EX_is_muldiv (1 each), ID_EX_ALUOp (4): the registered ID/EX stage contents.
REQ-012 The block SHALL have port: stall  output  1  hold PC and IF/ID this cycle.
REQ-013 The block SHALL have port: ex_busy  output  1  multi-cycle operation occupying EX.

Function
REQ-014 ID_EX_wr SHALL be registered as IF_ID_rd when RegDst=1, else IF_ID_rt.
REQ-015 A load-use hazard SHALL be ID_EX_valid & ID_EX_MemRead & ID_EX_wr!=0 & IF_ID_valid & (ID_EX_wr==IF_ID_rs | (IF_ID_uses_rt & ID_EX_wr==IF_ID_rt)).
REQ-016 The FSM SHALL have states RUN and MD_BUSY plus a down-counter of width 4.
REQ-017 Per rising edge, priority SHALL be: flush > MD_BUSY hold > load-use bubble > normal load.
REQ-018 On flush, the stage SHALL load a bubble (valid and all control outputs 0, data/specifier outputs 0), go to RUN, clear the counter.
REQ-019 In MD_BUSY without flush, all ID_EX outputs SHALL hold, and the counter SHALL decrement; at counter==1 the next state SHALL be RUN.
REQ-020 In RUN with a load-use hazard, the stage SHALL load a bubble; IF/ID contents are not consumed.
REQ-021 In RUN with no hazard, the stage SHALL load all inputs; IF_ID_valid=0 SHALL load a bubble.
REQ-022 Loading a valid instruction with is_muldiv=1 SHALL enter MD_BUSY with counter=MULDIV_LAT-1, so that EX occupancy totals MULDIV_LAT cycles.
REQ-023 ex_busy SHALL be 1 exactly when state==MD_BUSY.
REQ-024 stall SHALL be combinational: (load-use hazard | ex_busy) & ~flush.
REQ-025 A flush arriving in the same cycle as a hazard or in MD_BUSY SHALL win and SHALL deassert stall that cycle.

Reset
REQ-026 rst=1 SHALL asynchronously force state RUN, counter 0, ID_EX_valid 0, and every registered output to 0.
REQ-027 Reset mid-MD_BUSY SHALL abandon the operation; the first edge after release SHALL behave as RUN.

Structure
REQ-028 Package pipe_pkg SHALL hold the FSM state encoding, the ALUOp width, and the default MULDIV_LAT.
REQ-029 Load-use detection SHALL be a combinational sub-module, hazard_detect; the registers and FSM SHALL live in id_ex_stage.

Verification
REQ-030 Scenario lw $t0 (wr=8, MemRead) followed by add with rs=8: stall=1 for one cycle, then a bubble in ID_EX, and add enters on the next edge.
REQ-031 Scenario lw wr=0 followed by a reader of $0: stall=0 and no bubble.
REQ-032 Scenario mult with MULDIV_LAT=4: ex_busy=1 and stall=1 for 3 cycles after load, and outputs are held; the next instruction loads on the 4th edge.
REQ-033 Scenario flush during the 2nd MD_BUSY cycle: the next edge produces a bubble, ex_busy=0, and stall=0 in the flush cycle.
REQ-034 Scenario rst pulsed asynchronously mid-cycle with valid=1: all outputs are 0 immediately, without waiting for a clk edge.
REQ-035 Scenario lw wr=9 followed by sw with rt=9 and IF_ID_uses_rt=1: stall is asserted; with IF_ID_uses_rt=0 and rt=9 (e.g. addi), stall is not asserted.
